// File: rtl/w0rm_core_fetch.sv
// w0rm_core_fetch: credit-based instruction fetch unit.
// Issues in-order memory requests, buffers the responses with their PCs in a
// small FIFO, and presents them to decode. A redirect from the branch unit
// reloads the PC, clears the FIFO and drops any responses still in flight.
// Optional macro W0RM_FETCH_STATS_EN adds a saturating 16-bit counter of
// discarded instructions (output fetch_discard_count).
module w0rm_core_fetch #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] START_PC   = '0,
   parameter int                    FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  flush_pipeline,
   input  logic                  next_pc_valid,
   input  logic [DATA_WIDTH-1:0] next_pc,
   output logic                  inst_mem_req,
   output logic [DATA_WIDTH-1:0] inst_mem_addr,
   input  logic                  inst_mem_ready,
   input  logic                  inst_mem_data_valid,
   input  logic [DATA_WIDTH-1:0] inst_mem_data,
   output logic                  decode_valid,
   output logic [DATA_WIDTH-1:0] decode_inst,
   output logic [DATA_WIDTH-1:0] decode_pc,
   input  logic                  decode_ready
`ifdef W0RM_FETCH_STATS_EN
   ,
   output logic [15:0]           fetch_discard_count
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(DATA_WIDTH / 8);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                state_reg, state_next;
   logic [DATA_WIDTH-1:0] pc_reg, pc_next;
   logic [DATA_WIDTH-1:0] resp_pc_reg, resp_pc_next;   // PC of the oldest live request
   logic [CW-1:0]         outstanding_reg, outstanding_next;
   logic [CW-1:0]         discard_reg, discard_next;
   logic [CW-1:0]         count_reg, count_next;
   logic [AW-1:0]         rd_ptr_reg, rd_ptr_next;
   logic [AW-1:0]         wr_ptr_reg, wr_ptr_next;
   logic                  hold_reg, hold_next;        // suppresses a request right after a redirect

   logic [DATA_WIDTH-1:0] inst_mem_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] pc_mem_q   [FIFO_DEPTH];

   logic redirect, credit, accept, resp_live, resp_drop, push, pop;

   // Handshake decode; credits count both in-flight requests and buffered entries
   always_comb begin
      redirect     = flush_pipeline | next_pc_valid;
      credit       = ({1'b0, outstanding_reg} + {1'b0, count_reg}) < (CW+1)'(FIFO_DEPTH);
      inst_mem_req = (state_reg == RUN) && !hold_reg && credit;
      accept       = inst_mem_req && inst_mem_ready;
      resp_live    = inst_mem_data_valid && (state_reg == RUN) && (outstanding_reg != '0);
      resp_drop    = inst_mem_data_valid && (state_reg == DRAIN) && (discard_reg != '0);
      decode_valid = (count_reg != '0);
      push         = resp_live && !redirect;
      pop          = decode_valid && decode_ready && !redirect;
      decode_inst  = decode_valid ? inst_mem_q[rd_ptr_reg] : '0;
      decode_pc    = decode_valid ? pc_mem_q[rd_ptr_reg] : '0;
      inst_mem_addr = pc_reg;
   end

   // Next-state logic: redirect overrides push, pop and PC increment
   always_comb begin
      state_next       = state_reg;
      pc_next          = pc_reg;
      resp_pc_next     = resp_pc_reg;
      outstanding_next = outstanding_reg;
      discard_next     = discard_reg;
      count_next       = count_reg;
      rd_ptr_next      = rd_ptr_reg;
      wr_ptr_next      = wr_ptr_reg;
      hold_next        = 1'b0;
      case (state_reg)
         IDLE: state_next = RUN;
         RUN: begin
            if (redirect) begin
               pc_next          = next_pc;
               resp_pc_next     = next_pc;
               count_next       = '0;
               rd_ptr_next      = '0;
               wr_ptr_next      = '0;
               outstanding_next = '0;
               // a response landing in this cycle is consumed and dropped here
               discard_next     = outstanding_reg + CW'(accept) - CW'(resp_live);
               hold_next        = 1'b1;
               state_next       = (discard_next != '0) ? DRAIN : RUN;
            end else begin
               if (accept) pc_next = pc_reg + PC_STEP;
               outstanding_next = outstanding_reg + CW'(accept) - CW'(resp_live);
               if (push) begin
                  wr_ptr_next  = wr_ptr_reg + 1'b1;
                  resp_pc_next = resp_pc_reg + PC_STEP;
               end
               if (pop) rd_ptr_next = rd_ptr_reg + 1'b1;
               count_next = count_reg + CW'(push) - CW'(pop);
            end
         end
         DRAIN: begin
            if (redirect) begin
               pc_next      = next_pc;
               resp_pc_next = next_pc;
            end
            if (resp_drop) discard_next = discard_reg - 1'b1;
            if (discard_next == '0) state_next = RUN;
         end
         default: state_next = IDLE;
      endcase
   end

   // Control state registers with asynchronous reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg       <= IDLE;
         pc_reg          <= START_PC;
         resp_pc_reg     <= START_PC;
         outstanding_reg <= '0;
         discard_reg     <= '0;
         count_reg       <= '0;
         rd_ptr_reg      <= '0;
         wr_ptr_reg      <= '0;
         hold_reg        <= 1'b0;
      end else begin
         state_reg       <= state_next;
         pc_reg          <= pc_next;
         resp_pc_reg     <= resp_pc_next;
         outstanding_reg <= outstanding_next;
         discard_reg     <= discard_next;
         count_reg       <= count_next;
         rd_ptr_reg      <= rd_ptr_next;
         wr_ptr_reg      <= wr_ptr_next;
         hold_reg        <= hold_next;
      end
   end

   // FIFO storage: instruction word paired with the PC it was fetched from
   always_ff @(posedge clk) begin
      if (push) begin
         inst_mem_q[wr_ptr_reg] <= inst_mem_data;
         pc_mem_q[wr_ptr_reg]   <= resp_pc_reg;
      end
   end

`ifdef W0RM_FETCH_STATS_EN
   logic [CW:0] stat_inc;
   logic [16:0] stat_sum;

   // Discard tally: FIFO entries cleared plus responses thrown away
   always_comb begin
      stat_inc = '0;
      if (state_reg == RUN && redirect)
         stat_inc = {1'b0, count_reg} + (CW+1)'(resp_live);
      else if (resp_drop)
         stat_inc = (CW+1)'(1);
      stat_sum = {1'b0, fetch_discard_count} + 17'(stat_inc);
   end

   // Saturating statistics counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         fetch_discard_count <= '0;
      else
         fetch_discard_count <= stat_sum[16] ? 16'hFFFF : stat_sum[15:0];
   end
`endif

endmodule

// File: tb/tb_w0rm_core_fetch.sv
// Directed testbench for w0rm_core_fetch (DATA_WIDTH=32, START_PC=0, FIFO_DEPTH=4).
// A bench-side memory model queues accepted addresses and answers them in order.
module tb_w0rm_core_fetch;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        flush_pipeline = 1'b0;
   logic        next_pc_valid = 1'b0;
   logic [31:0] next_pc = '0;
   logic        inst_mem_req;
   logic [31:0] inst_mem_addr;
   logic        inst_mem_ready = 1'b1;
   logic        inst_mem_data_valid = 1'b0;
   logic [31:0] inst_mem_data = '0;
   logic        decode_valid;
   logic [31:0] decode_inst;
   logic [31:0] decode_pc;
   logic        decode_ready = 1'b1;
`ifdef W0RM_FETCH_STATS_EN
   logic [15:0] fetch_discard_count;
`endif

   int checks = 0;
   int errors = 0;
   int pops = 0;
   int accepts = 0;
   int rel_cnt = 0;
   bit mem_auto = 1'b1;
   logic [31:0] exp_addr = '0;
   logic [31:0] exp_pc = '0;
   logic [31:0] pend [$];

   w0rm_core_fetch #(.DATA_WIDTH(32), .START_PC(32'h0), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .flush_pipeline(flush_pipeline), .next_pc_valid(next_pc_valid), .next_pc(next_pc),
      .inst_mem_req(inst_mem_req), .inst_mem_addr(inst_mem_addr), .inst_mem_ready(inst_mem_ready),
      .inst_mem_data_valid(inst_mem_data_valid), .inst_mem_data(inst_mem_data),
      .decode_valid(decode_valid), .decode_inst(decode_inst), .decode_pc(decode_pc),
      .decode_ready(decode_ready)
`ifdef W0RM_FETCH_STATS_EN
      , .fetch_discard_count(fetch_discard_count)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: sample before the edge, then update the memory model after it
   task automatic step();
      bit acc;
      logic [31:0] a;
      acc = inst_mem_req && inst_mem_ready;
      a   = inst_mem_addr;
      if (inst_mem_req) check("req_addr", inst_mem_addr, exp_addr);
      if (acc) begin
         exp_addr = exp_addr + 32'd4;
         accepts++;
      end
      if (decode_valid && decode_ready) begin
         check("decode_pc", decode_pc, exp_pc);
         check("decode_inst", decode_inst, mem_word(exp_pc));
         exp_pc = exp_pc + 32'd4;
         pops++;
      end
      @(posedge clk);
      #1;
      if (acc) pend.push_back(a);
      if (pend.size() > 0 && (mem_auto || rel_cnt > 0)) begin
         a = pend.pop_front();
         inst_mem_data_valid = 1'b1;
         inst_mem_data = mem_word(a);
         if (rel_cnt > 0) rel_cnt--;
      end else begin
         inst_mem_data_valid = 1'b0;
         inst_mem_data = '0;
      end
      $display("step t=%0t req=%b addr=%h dv=%b dpc=%h", $time, inst_mem_req, inst_mem_addr, decode_valid, decode_pc);
   endtask

   // Assert reset between edges, check outputs immediately, release and wait for IDLE->RUN
   task automatic do_reset();
      #2;
      reset_n = 1'b0;
      pend.delete();
      inst_mem_data_valid = 1'b0;
      rel_cnt = 0;
      #1;
      check("rst_req", {31'b0, inst_mem_req}, 32'd0);
      check("rst_addr", inst_mem_addr, 32'h0);
      check("rst_dvalid", {31'b0, decode_valid}, 32'd0);
      check("rst_dinst", decode_inst, 32'h0);
      check("rst_dpc", decode_pc, 32'h0);
`ifdef W0RM_FETCH_STATS_EN
      check("rst_stats", {16'h0, fetch_discard_count}, 32'd0);
`endif
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      exp_addr = 32'h0;
      exp_pc = 32'h0;
      @(posedge clk);
      #1;
      check("first_req", {31'b0, inst_mem_req}, 32'd1);
      check("first_addr", inst_mem_addr, 32'h0);
   endtask

   task automatic redirect(input logic [31:0] tgt, input bit use_flush);
      if (use_flush) flush_pipeline = 1'b1;
      else next_pc_valid = 1'b1;
      next_pc = tgt;
      step();
      flush_pipeline = 1'b0;
      next_pc_valid = 1'b0;
      exp_addr = tgt;
   endtask

   initial begin
      // Streaming fetch, 1-cycle memory, decode always ready
      do_reset();
      step();
      check("stream_addr1", inst_mem_addr, 32'h4);
      repeat (3) step();
      pops = 0;
      repeat (8) step();
      check("throughput", pops, 8);

      // Reset in the middle of RUN
      do_reset();

      // Decode stalled: only FIFO_DEPTH requests may be issued
      decode_ready = 1'b0;
      accepts = 0;
      repeat (10) step();
      check("stall_accepts", accepts, 4);
      check("stall_req", {31'b0, inst_mem_req}, 32'd0);
      check("stall_dvalid", {31'b0, decode_valid}, 32'd1);
      decode_ready = 1'b1;
      pops = 0;
      repeat (4) step();
      check("stall_pops", pops, 4);

      // Memory not ready for 3 cycles: address held, then advances once
      inst_mem_ready = 1'b0;
      do_reset();
      repeat (3) begin
         step();
         check("hold_addr", inst_mem_addr, 32'h0);
         check("hold_req", {31'b0, inst_mem_req}, 32'd1);
      end
      inst_mem_ready = 1'b1;
      step();
      check("adv_addr", inst_mem_addr, 32'h4);
      inst_mem_ready = 1'b0;
      step();
      check("adv_once", inst_mem_addr, 32'h4);

      // Redirect with 2 responses outstanding and 2 entries buffered
      inst_mem_ready = 1'b1;
      decode_ready = 1'b0;
      mem_auto = 1'b0;
      do_reset();
      repeat (4) step();
      rel_cnt = 2;
      repeat (3) step();
      check("pre_flush_dvalid", {31'b0, decode_valid}, 32'd1);
      redirect(32'h100, 1'b1);
      check("flush_dvalid", {31'b0, decode_valid}, 32'd0);
      check("flush_req", {31'b0, inst_mem_req}, 32'd0);
      rel_cnt = 2;
      step();
      check("drain_req1", {31'b0, inst_mem_req}, 32'd0);
      step();
      check("drain_req2", {31'b0, inst_mem_req}, 32'd0);
      step();
      check("post_drain_req", {31'b0, inst_mem_req}, 32'd1);
      check("post_drain_addr", inst_mem_addr, 32'h100);
      check("post_drain_dvalid", {31'b0, decode_valid}, 32'd0);
`ifdef W0RM_FETCH_STATS_EN
      check("discard_count", {16'h0, fetch_discard_count}, 32'd4);
`endif
      exp_pc = 32'h100;
      decode_ready = 1'b1;
      mem_auto = 1'b1;
      pops = 0;
      repeat (6) step();
      check("redirect_pops", pops, 4);

      // PC wrap-around from 0xFFFFFFFC
      inst_mem_ready = 1'b0;
      repeat (6) step();
      redirect(32'hFFFF_FFFC, 1'b0);
      check("wrap_hold_req", {31'b0, inst_mem_req}, 32'd0);
      check("wrap_dvalid", {31'b0, decode_valid}, 32'd0);
      step();
      check("wrap_req", {31'b0, inst_mem_req}, 32'd1);
      check("wrap_addr0", inst_mem_addr, 32'hFFFF_FFFC);
      inst_mem_ready = 1'b1;
      exp_pc = 32'hFFFF_FFFC;
      pops = 0;
      step();
      check("wrap_addr1", inst_mem_addr, 32'h0);
      repeat (3) step();
      check("wrap_pops", pops, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
